d_branch_pred_cmp: RTL and testbench

- Parametrised decode-stage branch resolver for the five-stage MIPS pipeline; successor to the D-stage comparator.
- Adds a PC-indexed 2-bit saturating-counter pattern history table (PHT). F stage gets a taken/not-taken prediction; D stage resolves the branch, flags mispredicts and trains the table.
- Keeps branch/mispredict statistics counters for the CP0/debug read path.

---
 rtl/d_branch_pred_cmp_pkg.sv | 35 +++
 rtl/branch_cond_cmp.sv | 47 ++++
 rtl/d_branch_pred_cmp.sv | 115 +++++++++++
 tb/tb_d_branch_pred_cmp.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_branch_pred_cmp_pkg.sv
// Shared definitions for the decode-stage branch resolver and predictor.
//   - Compare-operation codes driven on D_CMPOp.
//   - Encodings of the 2-bit saturating pattern-history counter.
//   - cnt_update: next value of a PHT counter after one resolved branch.
package d_branch_pred_cmp_pkg;

    // Compare operation codes; 9..15 are unused and resolve not-taken.
    localparam logic [3:0] CMP_EQ       = 4'd0;
    localparam logic [3:0] CMP_OPPOSITE = 4'd1;
    localparam logic [3:0] CMP_NE       = 4'd2;
    localparam logic [3:0] CMP_LEZ      = 4'd3;
    localparam logic [3:0] CMP_GTZ      = 4'd4;
    localparam logic [3:0] CMP_LTZ      = 4'd5;
    localparam logic [3:0] CMP_GEZ      = 4'd6;
    localparam logic [3:0] CMP_LTU      = 4'd7;
    localparam logic [3:0] CMP_GES      = 4'd8;

    // Saturating counter states; the MSB is the taken prediction.
    localparam logic [1:0] PHT_SNT = 2'd0;
    localparam logic [1:0] PHT_WNT = 2'd1;
    localparam logic [1:0] PHT_WT  = 2'd2;
    localparam logic [1:0] PHT_ST  = 2'd3;

    // Move the counter one step toward the resolved direction, saturating at both ends.
    function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cnt == PHT_ST) ? PHT_ST : (cnt + 2'd1);
        end else begin
            nxt = (cnt == PHT_SNT) ? PHT_SNT : (cnt - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cond_cmp.sv
// Combinational branch-condition comparator for the decode stage.
// Ports:
//   A, B     in  WIDTH  forwarded rs / rt operands
//   D_CMPOp  in  4      compare operation (see d_branch_pred_cmp_pkg)
//   D_branch out 1      branch condition; 0 for undefined operations
module branch_cond_cmp
    import d_branch_pred_cmp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       D_CMPOp,
    output logic             D_branch
);

    logic [WIDTH-1:0] w_neg_a;
    logic [WIDTH-1:0] w_neg_b;
    logic             w_sign_a;
    logic             w_sign_b;
    logic             w_a_zero;

    assign w_neg_a  = ~A + {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_neg_b  = ~B + {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_sign_a = A[WIDTH-1];
    assign w_sign_b = B[WIDTH-1];
    assign w_a_zero = (A == {WIDTH{1'b0}});

    // Select the branch condition for the requested operation.
    always_comb begin
        D_branch = 1'b0;
        case (D_CMPOp)
            CMP_EQ:       D_branch = (A == B);
            // The sign guards stop the most-negative value matching its own negation.
            CMP_OPPOSITE: D_branch = (~w_sign_a & (w_neg_a == B)) | (~w_sign_b & (w_neg_b == A));
            CMP_NE:       D_branch = (A != B);
            CMP_LEZ:      D_branch = w_sign_a | w_a_zero;
            CMP_GTZ:      D_branch = ~w_sign_a & ~w_a_zero;
            CMP_LTZ:      D_branch = w_sign_a;
            CMP_GEZ:      D_branch = ~w_sign_a;
            CMP_LTU:      D_branch = (A < B);
            CMP_GES:      D_branch = ($signed(A) >= $signed(B));
            default:      D_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/d_branch_pred_cmp.sv
// Decode-stage branch resolver with a PC-indexed 2-bit saturating PHT.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   f_pc / f_pred_taken F-stage PC and its zero-cycle PHT prediction
//   d_stall / d_flush   hold / clear the F->D prediction register
//   d_valid, d_is_branch, d_pc  D-stage instruction qualifiers and training PC
//   A, B, D_CMPOp       operands and compare operation
//   D_branch            combinational branch condition
//   d_pred_taken        prediction carried from F
//   d_mispredict        resolved direction differs from the carried prediction
//   stat_branches, stat_mispred  saturating statistics counters
module d_branch_pred_cmp
    import d_branch_pred_cmp_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter int         PHT_DEPTH = 64,
    parameter int         IDX_LSB   = 2,
    parameter logic [1:0] CNT_INIT  = 2'b01,
    parameter int         STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       f_pc,
    output logic              f_pred_taken,
    input  logic              d_stall,
    input  logic              d_flush,
    input  logic              d_valid,
    input  logic              d_is_branch,
    input  logic [31:0]       d_pc,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [3:0]        D_CMPOp,
    output logic              D_branch,
    output logic              d_pred_taken,
    output logic              d_mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    logic [1:0]        r_pht [PHT_DEPTH];
    logic              r_pred;
    logic [STAT_W-1:0] r_stat_br;
    logic [STAT_W-1:0] r_stat_mp;

    logic [IDX_W-1:0]  w_f_idx;
    logic [IDX_W-1:0]  w_d_idx;
    logic              w_branch;
    logic              w_train;
    logic              w_mispredict;
    logic              w_unused_pc;

    branch_cond_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .A        (A),
        .B        (B),
        .D_CMPOp  (D_CMPOp),
        .D_branch (w_branch)
    );

    assign w_f_idx      = f_pc[IDX_LSB +: IDX_W];
    assign w_d_idx      = d_pc[IDX_LSB +: IDX_W];
    // Only the index field of each PC matters; the rest is intentionally ignored.
    assign w_unused_pc  = ^{f_pc, d_pc};
    assign w_train      = d_valid & d_is_branch & ~d_stall;
    // Not masked by d_stall: the hazard unit decides what a stalled mispredict means.
    assign w_mispredict = d_valid & d_is_branch & (w_branch != r_pred);

    // Pattern history table: one entry trained per cycle; F reads pre-update values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                r_pht[i] <= CNT_INIT;
            end
        end else if (w_train) begin
            r_pht[w_d_idx] <= cnt_update(r_pht[w_d_idx], w_branch);
        end
    end

    // F->D prediction register: flush wins over stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred <= 1'b0;
        end else if (d_flush) begin
            r_pred <= 1'b0;
        end else if (!d_stall) begin
            r_pred <= f_pred_taken;
        end
    end

    // Branch / mispredict statistics, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_br <= {STAT_W{1'b0}};
            r_stat_mp <= {STAT_W{1'b0}};
        end else if (w_train) begin
            if (r_stat_br != {STAT_W{1'b1}}) begin
                r_stat_br <= r_stat_br + {{(STAT_W-1){1'b0}}, 1'b1};
            end
            if (w_mispredict && (r_stat_mp != {STAT_W{1'b1}})) begin
                r_stat_mp <= r_stat_mp + {{(STAT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign f_pred_taken  = r_pht[w_f_idx][1];
    assign D_branch      = w_branch;
    assign d_pred_taken  = r_pred;
    assign d_mispredict  = w_mispredict;
    assign stat_branches = r_stat_br;
    assign stat_mispred  = r_stat_mp;

endmodule

// File: tb/tb_d_branch_pred_cmp.sv
// Self-checking bench for d_branch_pred_cmp: compare table, directed
// prediction/training sequences, randomized traffic against a behavioural
// model, and a small-PHT/narrow-stat instance for aliasing and saturation.
module tb_d_branch_pred_cmp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst2_n;
    logic [31:0] f_pc, d_pc, A, B;
    logic [3:0]  op;
    logic        d_stall, d_flush, d_valid, d_is_branch;

    logic        f_pred, dbr, dpred, mis;
    logic [31:0] sbr, smp;
    logic        sm_f_pred, sm_dbr, sm_dpred, sm_mis;
    logic [3:0]  sm_sbr, sm_smp;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model of the default instance.
    int     pht_m [64];
    int     pred_m;
    longint br_m, mp_m;
    localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp;
    } cmp_vec_t;
    cmp_vec_t vecs[$];

    always #5 clk = ~clk;

    d_branch_pred_cmp dut (
        .clk(clk), .rst_n(rst_n), .f_pc(f_pc), .f_pred_taken(f_pred),
        .d_stall(d_stall), .d_flush(d_flush), .d_valid(d_valid),
        .d_is_branch(d_is_branch), .d_pc(d_pc), .A(A), .B(B), .D_CMPOp(op),
        .D_branch(dbr), .d_pred_taken(dpred), .d_mispredict(mis),
        .stat_branches(sbr), .stat_mispred(smp)
    );

    d_branch_pred_cmp #(.PHT_DEPTH(4), .STAT_W(4)) dut_sm (
        .clk(clk), .rst_n(rst2_n), .f_pc(f_pc), .f_pred_taken(sm_f_pred),
        .d_stall(d_stall), .d_flush(d_flush), .d_valid(d_valid),
        .d_is_branch(d_is_branch), .d_pc(d_pc), .A(A), .B(B), .D_CMPOp(op),
        .D_branch(sm_dbr), .d_pred_taken(sm_dpred), .d_mispredict(sm_mis),
        .stat_branches(sm_sbr), .stat_mispred(sm_smp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Branch condition straight from the operation definitions, using integer arithmetic.
    function automatic logic ref_cmp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic [31:0] na, nb;
        sa = $signed(a);
        sb = $signed(b);
        na = 32'd0 - a;
        nb = 32'd0 - b;
        case (o)
            4'd0:    return a == b;
            4'd1:    return ((sa >= 0) && (na == b)) || ((sb >= 0) && (nb == a));
            4'd2:    return a != b;
            4'd3:    return sa <= 0;
            4'd4:    return sa > 0;
            4'd5:    return sa < 0;
            4'd6:    return sa >= 0;
            4'd7:    return a < b;
            4'd8:    return sa >= sb;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx64(input logic [31:0] pc);
        return int'((pc >> 2) % 32'd64);
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 64; i++) pht_m[i] = 1;
        pred_m = 0;
        br_m   = 0;
        mp_m   = 0;
    endtask

    // Advance the model by one clock edge using the current inputs, then let the DUT take the same edge.
    task automatic tick();
        logic br, mp;
        int   fp, di;
        br = ref_cmp(op, A, B);
        fp = pht_m[idx64(f_pc)] / 2;
        di = idx64(d_pc);
        mp = d_valid && d_is_branch && (int'(br) != pred_m);
        if (d_valid && d_is_branch && !d_stall) begin
            if (br) pht_m[di] = (pht_m[di] == 3) ? 3 : pht_m[di] + 1;
            else    pht_m[di] = (pht_m[di] == 0) ? 0 : pht_m[di] - 1;
            if (br_m < MAX32) br_m++;
            if (mp && (mp_m < MAX32)) mp_m++;
        end
        if (d_flush)       pred_m = 0;
        else if (!d_stall) pred_m = fp;
        @(posedge clk);
        #1;
    endtask

    // Settle combinational paths and compare every output against the model.
    task automatic check_comb(input string tag);
        logic br;
        #1;
        br = ref_cmp(op, A, B);
        chk({tag, " D_branch"},      {31'd0, dbr},   {31'd0, br});
        chk({tag, " f_pred_taken"},  {31'd0, f_pred}, (pht_m[idx64(f_pc)] >= 2) ? 32'd1 : 32'd0);
        chk({tag, " d_pred_taken"},  {31'd0, dpred}, 32'(pred_m));
        chk({tag, " d_mispredict"},  {31'd0, mis},
            {31'd0, (d_valid && d_is_branch && (int'(br) != pred_m))});
        chk({tag, " stat_branches"}, sbr, 32'(br_m));
        chk({tag, " stat_mispred"},  smp, 32'(mp_m));
    endtask

    initial begin
        logic [31:0] saved_br;
        logic [31:0] saved_mp;

        // Compare table (d_valid=0 so it never trains).
        vecs.push_back('{4'd0, 32'd7, 32'd7, 1'b1});
        vecs.push_back('{4'd0, 32'd7, 32'd8, 1'b0});
        vecs.push_back('{4'd1, 32'd5, 32'hFFFF_FFFB, 1'b1});
        vecs.push_back('{4'd1, 32'd0, 32'd0, 1'b1});
        vecs.push_back('{4'd1, 32'd5, 32'd5, 1'b0});
        vecs.push_back('{4'd1, 32'h8000_0000, 32'h8000_0000, 1'b0});
        vecs.push_back('{4'd2, 32'd1, 32'd2, 1'b1});
        vecs.push_back('{4'd2, 32'd3, 32'd3, 1'b0});
        vecs.push_back('{4'd3, 32'd0, 32'd9, 1'b1});
        vecs.push_back('{4'd3, 32'hFFFF_FFFF, 32'd0, 1'b1});
        vecs.push_back('{4'd3, 32'd1, 32'd0, 1'b0});
        vecs.push_back('{4'd4, 32'd1, 32'd0, 1'b1});
        vecs.push_back('{4'd4, 32'd0, 32'd0, 1'b0});
        vecs.push_back('{4'd4, 32'h8000_0000, 32'd0, 1'b0});
        vecs.push_back('{4'd5, 32'hFFFF_FFFF, 32'd1, 1'b1});
        vecs.push_back('{4'd5, 32'd0, 32'd0, 1'b0});
        vecs.push_back('{4'd6, 32'd0, 32'd0, 1'b1});
        vecs.push_back('{4'd6, 32'h8000_0000, 32'd0, 1'b0});
        vecs.push_back('{4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0});
        vecs.push_back('{4'd7, 32'd1, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{4'd7, 32'd3, 32'd3, 1'b0});
        vecs.push_back('{4'd8, 32'hFFFF_FFFF, 32'd1, 1'b0});
        vecs.push_back('{4'd8, 32'd1, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{4'd8, 32'd5, 32'd5, 1'b1});
        vecs.push_back('{4'd12, 32'd0, 32'd0, 1'b0});
        vecs.push_back('{4'd9, 32'd0, 32'd0, 1'b0});
        vecs.push_back('{4'd15, 32'hFFFF_FFFF, 32'd1, 1'b0});

        // Reset state.
        rst_n = 1'b0; rst2_n = 1'b0;
        d_stall = 1'b0; d_flush = 1'b0; d_valid = 1'b0; d_is_branch = 1'b0;
        f_pc = 32'h3000; d_pc = 32'h0; A = 32'd0; B = 32'd0; op = 4'd0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        chk("reset f_pred_taken", {31'd0, f_pred}, 32'd0);
        chk("reset d_pred_taken", {31'd0, dpred}, 32'd0);
        chk("reset stat_branches", sbr, 32'd0);
        chk("reset stat_mispred", smp, 32'd0);
        #3;
        rst_n = 1'b1; rst2_n = 1'b1;

        // Compare sweep with the prediction register held.
        d_stall = 1'b1;
        foreach (vecs[i]) begin
            op = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
            @(negedge clk);
            chk($sformatf("cmp op%0d %0h/%0h", vecs[i].op, vecs[i].a, vecs[i].b), {31'd0, dbr}, {31'd0, vecs[i].exp});
            chk("cmp mispredict idle", {31'd0, mis}, 32'd0);
        end
        d_stall = 1'b0;

        // Mispredict: F predicts not-taken for 0x3020, D resolves taken.
        f_pc = 32'h3020; d_valid = 1'b0; op = 4'd0; A = 32'd9; B = 32'd9;
        check_comb("mp0");
        chk("mp F predicts 0", {31'd0, f_pred}, 32'd0);
        tick();
        d_valid = 1'b1; d_is_branch = 1'b1; d_pc = 32'h3020;
        check_comb("mp1");
        chk("mp d_mispredict", {31'd0, mis}, 32'd1);
        tick();
        chk("mp stat_mispred", smp, 32'd1);
        chk("mp stat_branches", sbr, 32'd1);

        // Train up 0x3010 with a taken EQ, reading the same index in F.
        f_pc = 32'h3010; d_pc = 32'h3010; A = 32'd7; B = 32'd7;
        check_comb("tr0");
        tick();
        chk("train1 f_pred", {31'd0, f_pred}, 32'd1);
        chk("train1 same-index old value", {31'd0, dpred}, 32'd0);
        check_comb("tr1");
        tick(); check_comb("tr2");
        tick(); check_comb("tr3");
        chk("train3 d_pred", {31'd0, dpred}, 32'd1);
        B = 32'd8;
        tick();
        chk("not-taken keeps prediction", {31'd0, f_pred}, 32'd1);
        check_comb("tr4");

        // Stall three cycles: prediction, PHT and statistics frozen.
        saved_br = sbr; saved_mp = smp;
        d_stall = 1'b1; f_pc = 32'h3020; B = 32'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall d_pred holds", {31'd0, dpred}, 32'd1);
            chk("stall stat_branches", sbr, saved_br);
            chk("stall stat_mispred", smp, saved_mp);
            check_comb("stall");
        end
        f_pc = 32'h3010;
        #1;
        chk("stall PHT untouched", {31'd0, f_pred}, 32'd1);

        // Flush together with stall clears the register.
        d_flush = 1'b1;
        tick();
        chk("flush+stall clears", {31'd0, dpred}, 32'd0);
        check_comb("flush");
        d_flush = 1'b0; d_stall = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            f_pc        = 32'h3000 + (32'($urandom_range(0, 15)) << 2);
            d_pc        = 32'h3000 + (32'($urandom_range(0, 15)) << 2);
            d_valid     = ($urandom_range(0, 3) != 0);
            d_is_branch = ($urandom_range(0, 3) != 0);
            d_stall     = ($urandom_range(0, 4) == 0);
            d_flush     = ($urandom_range(0, 9) == 0);
            op          = 4'($urandom_range(0, 15));
            A           = $urandom;
            case ($urandom_range(0, 4))
                0:       B = A;
                1:       B = 32'd0 - A;
                2:       begin A = 32'd0; B = $urandom; end
                3:       B = A ^ 32'h8000_0000;
                default: B = $urandom;
            endcase
            check_comb("rand");
            tick();
        end
        d_stall = 1'b0; d_flush = 1'b0;

        // Small instance: aliasing of 0x3000/0x3010 and stat saturation.
        rst2_n = 1'b0;
        #1;
        chk("sm reset f_pred", {31'd0, sm_f_pred}, 32'd0);
        chk("sm reset d_pred", {31'd0, sm_dpred}, 32'd0);
        chk("sm reset stat_branches", {28'd0, sm_sbr}, 32'd0);
        rst2_n = 1'b1;
        d_valid = 1'b1; d_is_branch = 1'b1; d_pc = 32'h3000; f_pc = 32'h3010;
        op = 4'd0; A = 32'd1; B = 32'd1;
        #1;
        chk("sm D_branch", {31'd0, sm_dbr}, 32'd1);
        chk("sm mispredict", {31'd0, sm_mis}, 32'd1);
        tick();
        chk("sm alias 0x3010 sees training", {31'd0, sm_f_pred}, 32'd1);
        chk("sm stat_mispred", {28'd0, sm_smp}, 32'd1);
        f_pc = 32'h3000;
        #1;
        chk("sm alias 0x3000", {31'd0, sm_f_pred}, 32'd1);
        d_pc = 32'h3010; B = 32'd2;
        tick();
        chk("sm alias untrain", {31'd0, sm_f_pred}, 32'd0);
        chk("sm stat_mispred steady", {28'd0, sm_smp}, 32'd1);
        chk("sm stat_branches 2", {28'd0, sm_sbr}, 32'd2);
        for (int i = 0; i < 13; i++) tick();
        chk("sm stat_branches 15", {28'd0, sm_sbr}, 32'd15);
        for (int i = 0; i < 5; i++) tick();
        chk("sm stat_branches saturated", {28'd0, sm_sbr}, 32'd15);
        check_comb("post-sm");

        // Drive entry 0x3040 to strongly taken so the register holds 1, then reset mid-cycle.
        d_pc = 32'h3040; f_pc = 32'h3040; A = 32'd4; B = 32'd4; op = 4'd0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre-reset d_pred", {31'd0, dpred}, 32'd1);
        check_comb("pre-reset");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset f_pred", {31'd0, f_pred}, 32'd0);
        chk("async reset d_pred", {31'd0, dpred}, 32'd0);
        chk("async reset stat_branches", sbr, 32'd0);
        chk("async reset stat_mispred", smp, 32'd0);
        reset_model();
        #1;
        rst_n = 1'b1;
        tick();
        check_comb("post-reset1");
        tick();
        check_comb("post-reset2");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
